// File: rtl/ram_stream_pkg.sv
// Shared constants and types for the RAM read-side streaming controller.
package ram_stream_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry synchronous FIFO; the head entry is presented directly on head.
module stream_fifo2
  import ram_stream_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count,
  output logic              full,
  output logic              empty
);

  // Pointers are one bit wide: the storage is fixed at two entries.
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic [1:0]        count_q;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && (count_q != 2'd0);
  assign do_push = push && ((count_q != 2'(FIFO_DEPTH)) || do_pop);

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == 2'(FIFO_DEPTH));
  assign empty = (count_q == 2'd0);

  // Storage, pointers and occupancy update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// Streams a block of bytes out of a registered-read RAM onto a valid/ready
// interface, absorbing the one-cycle read latency with a 2-entry FIFO.
module ram_stream_reader
  import ram_stream_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] baseAddr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] readAddr,
  output logic              readEn,
  input  logic [DATA_W-1:0] ramData,
  output logic [DATA_W-1:0] outData,
  output logic              outValid,
  input  logic              outReady
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  issued_q;
  logic [CNT_W-1:0]  issued_d;
  logic [CNT_W-1:0]  accepted_q;
  logic [CNT_W-1:0]  accepted_d;
  logic              inflight_q;
  logic              busy_q;
  logic              done_q;
  logic              done_d;

  logic [1:0]        fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              capture;
  logic [2:0]        occupancy;
  logic              space_ok;
  logic              issue;

  // Output buffer; every RAM return is pushed, the issue credit keeps it from overflowing.
  stream_fifo2 #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight_q),
    .push_data(ramData),
    .pop      (pop),
    .head     (outData),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign outValid = !fifo_empty;
  assign pop      = outValid && outReady;
  assign capture  = (state_q == IDLE) && start;

  // Bytes that will still be held after this cycle: buffered plus in flight, minus the pop.
  assign occupancy = 3'(fifo_count) + 3'(inflight_q) - 3'(pop);
  // A full FIFO frees a slot only when it pops with nothing in flight.
  assign space_ok  = fifo_full ? (pop && !inflight_q) : (occupancy < 3'(FIFO_DEPTH));
  assign issue     = (state_q == READ) && space_ok;

  assign readEn   = issue;
  assign readAddr = base_q + issued_q[ADDR_W-1:0];
  assign busy     = busy_q;
  assign done     = done_q;

  // Next-state, counter and completion logic.
  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    accepted_d = accepted_q;
    done_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          issued_d   = '0;
          accepted_d = '0;
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (issue) begin
          issued_d = issued_q + CNT_W'(1);
          if (issued_d == len_q) begin
            state_d = DRAIN;
          end
        end
        if (pop) begin
          accepted_d = accepted_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        if (pop) begin
          accepted_d = accepted_q + CNT_W'(1);
          if (accepted_d == len_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters, captured command and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      base_q     <= '0;
      len_q      <= '0;
      issued_q   <= '0;
      accepted_q <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      inflight_q <= issue;
      busy_q     <= (state_d != IDLE);
      done_q     <= done_d;
      if (capture) begin
        base_q <= baseAddr;
        len_q  <= length;
      end
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed and randomized bench for ram_stream_reader with a RAM model and a
// byte-queue reference built from the block-transfer rules.
module tb_ram_stream_reader;

  localparam int MODE_READY  = 0;
  localparam int MODE_PATTERN = 1;
  localparam int MODE_RANDOM = 2;
  localparam int MODE_STALL  = 3;
  localparam int MODE_IGNORE = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] baseAddr;
  logic [8:0] length;
  logic       busy;
  logic       done;
  logic [7:0] readAddr;
  logic       readEn;
  logic [7:0] ramData;
  logic [7:0] outData;
  logic       outValid;
  logic       outReady;

  logic [7:0] mem [256];

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  ram_stream_reader #(
    .ADDR_W(8),
    .DATA_W(8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .baseAddr(baseAddr),
    .length  (length),
    .busy    (busy),
    .done    (done),
    .readAddr(readAddr),
    .readEn  (readEn),
    .ramData (ramData),
    .outData (outData),
    .outValid(outValid),
    .outReady(outReady)
  );

  // Registered-read RAM: data appears the cycle after the enable.
  always @(posedge clk) begin
    if (readEn) ramData <= mem[readAddr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},     32'(busy),     32'd0);
    check({tag, " done"},     32'(done),     32'd0);
    check({tag, " readEn"},   32'(readEn),   32'd0);
    check({tag, " readAddr"}, 32'(readAddr), 32'd0);
    check({tag, " outValid"}, 32'(outValid), 32'd0);
    check({tag, " outData"},  32'(outData),  32'd0);
  endtask

  function automatic logic pick_ready(input int mode, input int j);
    case (mode)
      MODE_PATTERN: return (j % 3) == 0;
      MODE_RANDOM:  return 1'($urandom_range(0, 1));
      MODE_STALL:   return j >= 12;
      default:      return 1'b1;
    endcase
  endfunction

  // One transfer: called at posedge+2, returns at a sample point (posedge+2).
  task automatic run_xfer(input string name, input logic [7:0] base, input logic [8:0] len,
                          input int mode, input int abort_at, input bit chk_timing);
    logic [7:0] expq[$];
    logic [7:0] exp_byte;
    logic [7:0] prev_data = 8'h00;
    logic       hs;
    bit         prev_stall = 1'b0;
    int nlen = int'(len);
    int nread = 0, nacc = 0, ndone = 0, outst = 0;
    int addr_bad = 0, credit_bad = 0, stall_bad = 0, busy_bad = 0;
    int first_v = -1, done_j = -1;
    int budget = 4 * nlen + 60;

    for (int i = 0; i < nlen; i++) expq.push_back(mem[8'(int'(base) + i)]);

    start    = 1'b1;
    baseAddr = base;
    length   = len;
    @(posedge clk);
    for (int j = 0; j < budget; j++) begin
      #1;
      start = 1'b0;
      if (mode == MODE_IGNORE && j == 3) begin
        start    = 1'b1;
        baseAddr = base + 8'h55;
        length   = 9'd3;
      end
      outReady = pick_ready(mode, j);
      #1;
      if (j == 0 && busy !== (nlen != 0)) busy_bad++;
      hs = outValid && outReady;
      if (readEn) begin
        if (readAddr !== 8'(int'(base) + nread)) addr_bad++;
        if (nread >= nlen) addr_bad++;
        if (outst - int'(hs) >= 2) credit_bad++;
        nread++;
      end
      if (prev_stall && (!outValid || outData !== prev_data)) stall_bad++;
      if (outValid && first_v < 0) first_v = j;
      if (hs) begin
        exp_byte = (expq.size() > 0) ? expq.pop_front() : 8'hxx;
        check($sformatf("%s byte%0d", name, nacc), 32'(outData), 32'(exp_byte));
        nacc++;
      end
      if (done) begin
        ndone++;
        done_j = j;
        if (busy) busy_bad++;
      end
      outst     += int'(readEn) - int'(hs);
      prev_stall = outValid && !outReady;
      prev_data  = outData;
      if (abort_at > 0 && nacc == abort_at) break;
      if (done_j >= 0 && j >= done_j + 2) break;
      @(posedge clk);
    end
    start = 1'b0;

    if (abort_at > 0) begin
      check({name, " accepted before abort"}, 32'(nacc), 32'(abort_at));
    end else begin
      check({name, " reads issued"}, 32'(nread), 32'(nlen));
      check({name, " bytes accepted"}, 32'(nacc), 32'(nlen));
      check({name, " done pulses"}, 32'(ndone), 32'd1);
      check({name, " addr errors"}, 32'(addr_bad), 32'd0);
      check({name, " credit errors"}, 32'(credit_bad), 32'd0);
      check({name, " stall errors"}, 32'(stall_bad), 32'd0);
      check({name, " busy errors"}, 32'(busy_bad), 32'd0);
      if (chk_timing) begin
        if (nlen != 0) begin
          check({name, " first valid cycle"}, 32'(first_v), 32'd2);
          check({name, " done cycle"}, 32'(done_j), 32'(nlen + 2));
        end else begin
          check({name, " done cycle"}, 32'(done_j), 32'd0);
        end
      end
    end
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    baseAddr = 8'h00;
    length   = 9'd0;
    outReady = 1'b0;
    ramData  = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    #1 reset = 1'b1;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    run_xfer("basic",   8'h10, 9'd4,   MODE_READY,   0, 1'b1);
    run_xfer("wrap",    8'hFE, 9'd4,   MODE_READY,   0, 1'b1);
    run_xfer("backpr",  8'h20, 9'd8,   MODE_PATTERN, 0, 1'b0);
    run_xfer("stall",   8'h30, 9'd6,   MODE_STALL,   0, 1'b0);
    run_xfer("len0",    8'h50, 9'd0,   MODE_READY,   0, 1'b1);
    run_xfer("len256",  8'h80, 9'd256, MODE_READY,   0, 1'b1);
    run_xfer("ignore",  8'h60, 9'd8,   MODE_IGNORE,  0, 1'b1);

    // Abort after three bytes, then check outputs drop asynchronously.
    run_xfer("abort",   8'h70, 9'd8,   MODE_READY,   3, 1'b0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    run_xfer("after_reset", 8'h40, 9'd2, MODE_READY, 0, 1'b1);

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int t = 0; t < 6; t++) begin
      run_xfer($sformatf("rand%0d", t), 8'($urandom),
               9'($urandom_range(1, 40)), MODE_RANDOM, 0, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
